// File: rtl/usb_hub_pkg.sv
// Shared definitions for the hub's USB line logic: tx states, line encodings, CRC16 constants
// and the NRZI helper.
package usb_hub_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StCrc,
        StEop1,
        StEop2,
        StEopJ
    } tx_state_e;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Line encodings as {plus, minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // NRZI: a 0 toggles J<->K, a 1 holds the line.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic data_bit);
        if (data_bit) begin
            return line;
        end
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bitwise serial USB CRC16 (x^16+x^15+x^2+1), data bits fed LSB first.
module usb_crc16
    import usb_hub_pkg::*;
(
    input  logic        hi_clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_bit,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = data_bit ^ crc[15];

    always_ff @(posedge hi_clock or posedge reset) begin
        if (reset) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_fs_tx.sv
// Full-speed USB serial transmitter: SYNC, NRZI + bit-stuffed data LSB first, EOP.
// Define USB_TX_CRC16_EN to append the inverted CRC16 over the bytes after the PID.
module usb_fs_tx
    import usb_hub_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       hi_clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       host_tx_plus,
    output logic       host_tx_minus,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    tx_state_e       state;
    logic [CntW-1:0] bit_cnt;
    logic [3:0]      bit_idx;
    logic [2:0]      ones;
    logic [1:0]      line;
    logic [6:0]      shift_rest;
    logic [7:0]      hold_data;
    logic            hold_full;
    logic            hold_last;
    logic            cur_last;
    logic            last_seen;
    logic            underrun_q;
    logic            strobe;
    logic            accept;
    logic            sync_bit;

`ifdef USB_TX_CRC16_EN
    logic        payload;
    logic        stuff;
    logic        cur_bit;
    logic [14:0] crc_rest;
    logic [15:0] crc_val;
    logic [15:0] crc_inv;
    logic        crc_en;
    logic        crc_clear;

    // Feed each payload data bit once, in the first cycle of its bit period.
    assign crc_en    = (state == StData) && (bit_cnt == '0) && !stuff && payload;
    assign crc_clear = (state == StIdle);
    assign crc_inv   = ~crc_val;

    usb_crc16 u_crc16 (
        .hi_clock (hi_clock),
        .reset    (reset),
        .clear    (crc_clear),
        .enable   (crc_en),
        .data_bit (cur_bit),
        .crc      (crc_val)
    );
`endif

    assign strobe   = (bit_cnt == CntMax);
    assign tx_ready = !hold_full && !last_seen &&
                      ((state == StIdle) || (state == StSync) || (state == StData));
    assign accept   = tx_valid && tx_ready;
    assign sync_bit = SYNC_PATTERN[bit_idx[2:0] + 3'd1];

    assign host_tx_plus  = line[1];
    assign host_tx_minus = line[0];
    assign tx_busy       = (state != StIdle);
    assign tx_oe         = (state != StIdle);
    assign tx_underrun   = underrun_q;

    always_ff @(posedge hi_clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            ones       <= '0;
            line       <= LINE_J;
            shift_rest <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            hold_last  <= 1'b0;
            cur_last   <= 1'b0;
            last_seen  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef USB_TX_CRC16_EN
            payload    <= 1'b0;
            stuff      <= 1'b0;
            cur_bit    <= 1'b0;
            crc_rest   <= '0;
`endif
        end else begin
            underrun_q <= 1'b0;
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
                if (tx_last) begin
                    last_seen <= 1'b1;
                end
            end
            if (state != StIdle) begin
                bit_cnt <= strobe ? '0 : bit_cnt + 1'b1;
            end

            case (state)
                StIdle: begin
                    if (accept) begin
                        state   <= StSync;
                        line    <= nrzi_next(LINE_J, SYNC_PATTERN[0]);
                        bit_idx <= '0;
                        ones    <= '0;
                    end
                end

                StSync: begin
                    if (strobe) begin
                        if (bit_idx == 4'd7) begin
                            // The PID is always waiting in the holding register here.
                            state      <= StData;
                            shift_rest <= hold_data[7:1];
                            line       <= nrzi_next(line, hold_data[0]);
                            ones       <= hold_data[0] ? ones + 3'd1 : 3'd0;
                            cur_last   <= hold_last;
                            hold_full  <= 1'b0;
                            bit_idx    <= '0;
`ifdef USB_TX_CRC16_EN
                            payload    <= 1'b0;
                            stuff      <= 1'b0;
                            cur_bit    <= hold_data[0];
`endif
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            line    <= nrzi_next(line, sync_bit);
                            ones    <= sync_bit ? ones + 3'd1 : 3'd0;
                        end
                    end
                end

                StData: begin
                    if (strobe) begin
                        if (ones == 3'd6) begin
                            line <= nrzi_next(line, 1'b0);
                            ones <= '0;
`ifdef USB_TX_CRC16_EN
                            stuff <= 1'b1;
`endif
                        end else if (bit_idx != 4'd7) begin
                            bit_idx    <= bit_idx + 4'd1;
                            shift_rest <= {1'b0, shift_rest[6:1]};
                            line       <= nrzi_next(line, shift_rest[0]);
                            ones       <= shift_rest[0] ? ones + 3'd1 : 3'd0;
`ifdef USB_TX_CRC16_EN
                            stuff      <= 1'b0;
                            cur_bit    <= shift_rest[0];
`endif
                        end else if (cur_last) begin
`ifdef USB_TX_CRC16_EN
                            // USB sends the CRC register high bit first (reflected LSB first).
                            if (payload) begin
                                state    <= StCrc;
                                bit_idx  <= '0;
                                line     <= nrzi_next(line, crc_inv[15]);
                                ones     <= crc_inv[15] ? ones + 3'd1 : 3'd0;
                                crc_rest <= crc_inv[14:0];
                                stuff    <= 1'b0;
                            end else
`endif
                            begin
                                state <= StEop1;
                                line  <= LINE_SE0;
                            end
                        end else if (hold_full) begin
                            shift_rest <= hold_data[7:1];
                            line       <= nrzi_next(line, hold_data[0]);
                            ones       <= hold_data[0] ? ones + 3'd1 : 3'd0;
                            cur_last   <= hold_last;
                            hold_full  <= 1'b0;
                            bit_idx    <= '0;
`ifdef USB_TX_CRC16_EN
                            payload    <= 1'b1;
                            stuff      <= 1'b0;
                            cur_bit    <= hold_data[0];
`endif
                        end else begin
                            underrun_q <= 1'b1;
                            state      <= StEop1;
                            line       <= LINE_SE0;
                        end
                    end
                end

`ifdef USB_TX_CRC16_EN
                StCrc: begin
                    if (strobe) begin
                        if (ones == 3'd6) begin
                            line <= nrzi_next(line, 1'b0);
                            ones <= '0;
                        end else if (bit_idx != 4'd15) begin
                            bit_idx  <= bit_idx + 4'd1;
                            crc_rest <= {crc_rest[13:0], 1'b0};
                            line     <= nrzi_next(line, crc_rest[14]);
                            ones     <= crc_rest[14] ? ones + 3'd1 : 3'd0;
                        end else begin
                            state <= StEop1;
                            line  <= LINE_SE0;
                        end
                    end
                end
`endif

                StEop1: begin
                    if (strobe) begin
                        state <= StEop2;
                    end
                end

                StEop2: begin
                    if (strobe) begin
                        state <= StEopJ;
                        line  <= LINE_J;
                    end
                end

                StEopJ: begin
                    if (strobe) begin
                        state     <= StIdle;
                        last_seen <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    line  <= LINE_J;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_tx.sv
// Self-checking bench for usb_fs_tx: a packet-level line model (stuffing, NRZI, CRC) is compared
// cycle by cycle against the DUT outputs. Honours USB_TX_CRC16_EN when defined.
module tb_usb_fs_tx;

    localparam int CPB = 4;
    localparam logic [1:0] SJ  = 2'b10;
    localparam logic [1:0] SK  = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    typedef logic [7:0] byte_q_t[$];

    logic       hi_clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       host_tx_plus;
    logic       host_tx_minus;
    logic       tx_oe;
    logic       tx_busy;
    logic       tx_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];
    bit         exp_ur;

    usb_fs_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .hi_clock      (hi_clock),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .host_tx_plus  (host_tx_plus),
        .host_tx_minus (host_tx_minus),
        .tx_oe         (tx_oe),
        .tx_busy       (tx_busy),
        .tx_underrun   (tx_underrun)
    );

    always #5 hi_clock = ~hi_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // CRC-16/USB in reflected byte-wise form; result already inverted, sent LSB first.
    function automatic logic [15:0] usb_crc(input byte_q_t b);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 1; i < b.size(); i++) begin
            r = r ^ {8'h00, b[i]};
            for (int j = 0; j < 8; j++) begin
                r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
            end
        end
        return ~r;
    endfunction

    task automatic build_model(input byte_q_t b, input bit has_last);
        bit          bits[$];
        logic [1:0]  ln;
        int          ones;
        logic [15:0] c;
        exp_q.delete();
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) bits.push_back(b[i][j]);
        end
`ifdef USB_TX_CRC16_EN
        if (has_last && b.size() > 1) begin
            c = usb_crc(b);
            for (int j = 0; j < 16; j++) bits.push_back(c[j]);
        end
`else
        c = 16'h0;
`endif
        ln   = SJ;
        ones = 0;
        foreach (bits[i]) begin
            if (bits[i]) begin
                ones++;
            end else begin
                ln   = (ln == SJ) ? SK : SJ;
                ones = 0;
            end
            exp_q.push_back(ln);
            if (ones == 6) begin
                ln   = (ln == SJ) ? SK : SJ;
                ones = 0;
                exp_q.push_back(ln);
            end
        end
        exp_q.push_back(SE0);
        exp_q.push_back(SE0);
        exp_q.push_back(SJ);
        exp_ur = !has_last;
    endtask

    // Sends one packet with random producer gaps and checks the line every cycle.
    task automatic run_packet(input byte_q_t b, input bit has_last, input int max_gap,
                              output int oe_cycles, output int busy_cycles);
        int n, sent, k, wait_cnt, len;
        bit hs, just_acc, done;
        n = b.size();
        sent = 0; k = -1; wait_cnt = 0; just_acc = 0; done = 0;
        oe_cycles = 0; busy_cycles = 0;
        build_model(b, has_last);
        len = exp_q.size() * CPB;
        @(posedge hi_clock); #1;
        tx_data  = b[0];
        tx_last  = has_last && (n == 1);
        tx_valid = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge hi_clock);
            if (just_acc) check("ready_after_accept", 32'(tx_ready), 32'd0);
            if (k >= 0) begin
                if (tx_oe) oe_cycles++;
                if (tx_busy) busy_cycles++;
                if (k < len) begin
                    check("line", 32'({host_tx_plus, host_tx_minus}), 32'(exp_q[k / CPB]));
                    check("oe", 32'(tx_oe), 32'd1);
                    check("busy", 32'(tx_busy), 32'd1);
                    check("underrun", 32'(tx_underrun),
                          32'(exp_ur && (k == len - 3 * CPB)));
                end else begin
                    check("end_line", 32'({host_tx_plus, host_tx_minus}), 32'(SJ));
                    check("end_oe", 32'(tx_oe), 32'd0);
                    check("end_busy", 32'(tx_busy), 32'd0);
                    check("end_ready", 32'(tx_ready), 32'd1);
                    done = 1;
                end
                k++;
            end
            if (done) break;
            hs = tx_valid && tx_ready;
            @(posedge hi_clock); #1;
            just_acc = hs;
            if (hs) begin
                if (k < 0) k = 0;
                sent++;
                tx_valid = 1'b0;
                wait_cnt = $urandom_range(max_gap, 0);
            end
            if (!tx_valid && sent < n) begin
                if (wait_cnt == 0) begin
                    tx_data  = b[sent];
                    tx_last  = has_last && (sent == n - 1);
                    tx_valid = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        check("bytes_accepted", 32'(sent), 32'(n));
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    initial begin
        byte_q_t pkt;
        int      oe_c, busy_c, len, got;
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        #1;
        check("rst_line", 32'({host_tx_plus, host_tx_minus}), 32'(SJ));
        check("rst_oe", 32'(tx_oe), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge hi_clock);
        reset = 1'b0;

        pkt = '{8'hD2};
        run_packet(pkt, 1'b1, 0, oe_c, busy_c);
        check("ack_oe_cycles", 32'(oe_c), 32'(19 * CPB));

        pkt = '{8'hC3, 8'hFF};
        run_packet(pkt, 1'b1, 2, oe_c, busy_c);
        check("c3ff_busy_cycles", 32'(busy_c), 32'(exp_q.size() * CPB));

        pkt = '{8'hC3};
        run_packet(pkt, 1'b1, 0, oe_c, busy_c);
        check("data0_zlp_cycles", 32'(busy_c), 32'(19 * CPB));

        pkt = '{8'hC3, 8'h00};
        run_packet(pkt, 1'b1, 3, oe_c, busy_c);

        pkt = '{8'hC3};
        run_packet(pkt, 1'b0, 0, oe_c, busy_c);

        // Reset in the middle of DATA, then a clean ACK.
        @(posedge hi_clock); #1;
        tx_data  = 8'hD2;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge hi_clock);
            if (tx_valid && tx_ready) got = 1;
            @(posedge hi_clock); #1;
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        check("mid_accept", 32'(got), 32'd1);
        repeat (12 * CPB) @(posedge hi_clock);
        #2;
        check("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_line", 32'({host_tx_plus, host_tx_minus}), 32'(SJ));
        check("mid_rst_oe", 32'(tx_oe), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        @(negedge hi_clock);
        reset = 1'b0;
        pkt = '{8'hD2};
        run_packet(pkt, 1'b1, 0, oe_c, busy_c);
        check("ack2_oe_cycles", 32'(oe_c), 32'(19 * CPB));

        // Four bytes with tx_valid held high throughout.
        pkt = {};
        for (int i = 0; i < 4; i++) pkt.push_back(8'($urandom_range(255, 0)));
        run_packet(pkt, 1'b1, 0, oe_c, busy_c);

        for (int p = 0; p < 6; p++) begin
            pkt = {};
            len = $urandom_range(5, 1);
            for (int i = 0; i < len; i++) pkt.push_back(8'($urandom_range(255, 0)));
            run_packet(pkt, 1'b1, 4, oe_c, busy_c);
        end

        pkt = '{8'h4B, 8'hFF, 8'hFF};
        run_packet(pkt, 1'b0, 1, oe_c, busy_c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_fs_tx.md
# usb_fs_tx

Full-speed USB serial transmitter for the hub's upstream port. It accepts packet bytes (PID first) over a valid/ready byte stream and drives `host_tx_plus`/`host_tx_minus` with the line signalling:
- SYNC
- NRZI-encoded, bit-stuffed data, LSB first
- EOP (SE0, SE0, J)

It is the transmit counterpart of the upstream receive path and sits between the hub packet engine and the upstream pads inside `usb_hub_top`.

## Interface
- `CLKS_PER_BIT`, default 4: `hi_clock` cycles per USB bit period (48 MHz / 12 Mbps); minimum 2.
- `hi_clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  packet byte; byte 0 of a packet is the PID.
- `tx_valid`  in  1  `tx_data`/`tx_last` valid.
- `tx_last`  in  1  marks the final byte of the packet.
- `tx_ready`  out  1  block accepts a byte this cycle; transfer happens when `tx_valid && tx_ready`.
- `host_tx_plus`  out  1  D+ line drive value.
- `host_tx_minus`  out  1  D- line drive value.
- `tx_oe`  out  1  output enable for the upstream drivers.
- `tx_busy`  out  1  high from packet start through end of EOP.
- `tx_underrun`  out  1  one-cycle pulse on an aborted packet.

## Operation
- Line encodings:
  - J: plus=1, minus=0.
  - K: plus=0, minus=1.
  - SE0: both 0.
  - Outputs are J whenever the block is idle.
- One-byte holding register sits in front of an 8-bit shifter.
  - `tx_ready` = holding register empty AND state is IDLE, SYNC or DATA AND no `tx_last` byte accepted yet in this packet.
- States:
  - IDLE → SYNC when the first byte is accepted.
  - SYNC: 8 bit periods, pattern 0,0,0,0,0,0,0,1 → DATA.
  - DATA: shifts out bytes LSB first, loading the shifter from the holding register at each byte boundary.
  - After the `tx_last` byte's final bit (including any stuff bit) → EOP1.
  - EOP1 (SE0) → EOP2 (SE0) → EOPJ (J, `tx_oe` still 1) → IDLE.
- NRZI: data 0 toggles the line (J↔K); data 1 holds it. The NRZI state starts at J at SYNC.
- Bit stuffing:
  - The ones counter counts consecutive 1s, including SYNC's final 1.
  - After six consecutive 1s, a 0 (a transition) is inserted as an extra bit period and the counter clears.
  - Stuffing also applies when the sixth 1 is the last data bit of the packet; the stuff bit precedes EOP.
  - There is no stuffing in SYNC or EOP.
- Underrun:
  - At a DATA byte boundary, if the holding register is empty and `tx_last` has not been seen, pulse `tx_underrun` and go to EOP1.
  - The partial packet is not completed.
- `tx_busy` = state ≠ IDLE. `tx_oe` = state ∉ {IDLE}.

## Timing
- Reset values (also while `reset` is high):
  - state IDLE, holding register empty, `tx_ready`=1.
  - `host_tx_plus`=1, `host_tx_minus`=0.
  - `tx_oe`=0, `tx_busy`=0, `tx_underrun`=0.
- Reset asserted mid-packet returns all outputs to these values immediately (asynchronously). No EOP is sent.
- Bit timing:
  - A bit timer counts 0..CLKS_PER_BIT-1; a bit strobe occurs at the wrap.
  - Each line state is held for exactly CLKS_PER_BIT cycles.
- Packet start: the first SYNC K appears on the outputs, with `tx_oe`=1, in the cycle after the accepting edge.
- Byte rate:
  - `tx_ready` rises the cycle after the holding register drains into the shifter, i.e. one cycle after each byte boundary.
  - The producer has 8×CLKS_PER_BIT−1 cycles to supply the next byte.
- Packet length: 8 + 8N + S + 3 bit periods for N bytes with S stuff bits. `tx_busy` falls on the cycle the EOPJ period ends.
- Back-to-back: a new packet may be accepted in the first IDLE cycle. There is no added inter-packet gap; the packet engine owns that.

## Configuration
- `USB_TX_CRC16_EN` defined:
  - A CRC16 is computed over every byte after the PID: polynomial 0x8005 (x^16+x^15+x^2+1), init 0xFFFF.
  - After the `tx_last` byte, the inverted CRC is sent LSB first as 16 extra bits (stuffed like data), then EOP.
  - The producer sets `tx_last` on the final payload byte. A single-byte packet (handshake/token PID only) gets no CRC.
- Not defined: no CRC logic. Every byte is supplied by the producer; `tx_last` marks the true final byte.

## Structure
- Shared `usb_hub_pkg` holds:
  - the tx state enum;
  - `SYNC_PATTERN` = 8'h80;
  - the J/K/SE0 line encodings;
  - `CRC16_POLY` = 16'h8005 and `CRC16_INIT` = 16'hFFFF.
- Sub-module `usb_crc16`: bitwise serial CRC16 with clear, enable and data-bit inputs. Instantiated only under `USB_TX_CRC16_EN`; reused later by the receive path.

## Test plan
- ACK (0xD2, `tx_last`), CLKS_PER_BIT=4 → line shows KJKJKJKK JJKJJKKK, then SE0, SE0, J, each 4 cycles. `tx_oe` high for exactly 76 cycles; no underrun.
- Bytes 0xC3, 0xFF(last), macro off → one stuff transition inserted after the 4th bit of 0xFF. Data spans 17 bit periods and `tx_busy` lasts 28 bit periods.
- Macro on, DATA0 zero-length (0xC3, `tx_last`) → no CRC, 11+8 bit periods. Then 0xC3, 0x00(last) → CRC bits follow the 0x00 byte and match the reference model computed inline.
- Producer withholds the second byte of a two-byte-minimum packet → `tx_underrun` pulses one cycle at the byte boundary, followed by SE0, SE0, J, then IDLE with `tx_ready`=1.
- `reset` asserted in the middle of the DATA state → outputs become J, `tx_oe`=0, `tx_busy`=0 within the same cycle. After release, a new ACK is transmitted correctly.
- `tx_valid` held high with a stream of 4 bytes → each byte is accepted exactly once. `tx_ready` is never high while the holding register is full, and no bytes are dropped or duplicated.
